// File: rtl/systolic_pkg.sv
// Shared types for the systolic array: MAC operand/product widths, accumulator type
// and the accumulator FSM state encoding.
package systolic_pkg;

  localparam int MAC_DATA_W = 8;
  localparam int MAC_MUL_W  = 16;
  localparam int ACC_W_DEF  = MAC_MUL_W + $clog2(256);

  typedef logic signed [MAC_DATA_W-1:0] t_mac_data;
  typedef logic signed [MAC_MUL_W-1:0]  t_mac_mul_data;
  typedef logic signed [ACC_W_DEF-1:0]  t_acc_data;

  typedef enum logic {
    IDLE,
    ACCUM
  } t_acc_state;

endpackage

// File: rtl/acc_out_reg.sv
// One-entry result holding register with valid/ready handshake. A load that arrives
// while the entry is full and not being drained is dropped and flagged in a sticky bit.
module acc_out_reg #(
  parameter int W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic signed [W-1:0] load_data,
  input  logic                ready,
  input  logic                ovf_clear,
  output logic signed [W-1:0] data,
  output logic                valid,
  output logic                overflow
);

  logic signed [W-1:0] data_reg;
  logic                valid_reg;
  logic                overflow_reg;
  logic                drain;
  logic                collide;

  assign drain   = valid_reg && ready;
  assign collide = load && valid_reg && !ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      // A load during a drain cycle replaces the departing result without a bubble.
      if (load && (!valid_reg || ready)) begin
        data_reg  <= load_data;
        valid_reg <= 1'b1;
      end else if (drain) begin
        valid_reg <= 1'b0;
      end

      if (collide) begin
        overflow_reg <= 1'b1;
      end else if (ovf_clear) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign data     = data_reg;
  assign valid    = valid_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/mac_accumulator.sv
// Sums k_len valid MAC products into one dot-product result and hands it to a
// valid/ready output register. Define MAC_ACC_SATURATE_EN for saturating addition.
module mac_accumulator
  import systolic_pkg::*;
#(
  parameter int K_MAX = 256,
  parameter int ACC_W = MAC_MUL_W + $clog2(K_MAX)
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic [$clog2(K_MAX+1)-1:0]    k_len_i,
  input  t_mac_mul_data                 prod_i,
  input  logic                          prod_valid_i,
  output logic                          busy_o,
  output logic signed [ACC_W-1:0]       acc_o,
  output logic                          acc_valid_o,
  input  logic                          acc_ready_i,
  output logic                          overflow_o,
  input  logic                          ovf_clear_i
);

  localparam int CNT_W = $clog2(K_MAX + 1);

  t_acc_state              state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [CNT_W-1:0]        k_len_reg, k_len_next;
  logic signed [ACC_W-1:0] sum_reg, sum_next;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] add_res;
  logic                    start_ok;
  logic                    last_beat;

  assign prod_ext = {{(ACC_W-MAC_MUL_W){prod_i[MAC_MUL_W-1]}}, prod_i};

`ifdef MAC_ACC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [ACC_W:0] wide_sum;

  assign wide_sum = {sum_reg[ACC_W-1], sum_reg} + {prod_ext[ACC_W-1], prod_ext};

  // The two top bits disagree exactly when the signed addition left the ACC_W range.
  always_comb begin
    add_res = wide_sum[ACC_W-1:0];
    if (wide_sum[ACC_W] != wide_sum[ACC_W-1]) begin
      add_res = wide_sum[ACC_W] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign add_res = sum_reg + prod_ext;
`endif

  assign start_ok  = start_i && (k_len_i != '0) && (k_len_i <= CNT_W'(K_MAX));
  assign last_beat = (state_reg == ACCUM) && prod_valid_i && (cnt_reg == k_len_reg - 1'b1);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    k_len_next = k_len_reg;
    sum_next   = sum_reg;
    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          k_len_next = k_len_i;
          cnt_next   = '0;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (prod_valid_i) begin
          // The first beat overwrites, so the previous result never leaks in.
          sum_next = (cnt_reg == '0) ? prod_ext : add_res;
          cnt_next = cnt_reg + 1'b1;
          if (last_beat) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      k_len_reg <= '0;
      sum_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      k_len_reg <= k_len_next;
      sum_reg   <= sum_next;
    end
  end

  assign busy_o = (state_reg == ACCUM);

  acc_out_reg #(
    .W (ACC_W)
  ) u_out (
    .clk       (clock_i),
    .rst       (reset_i),
    .load      (last_beat),
    .load_data (sum_next),
    .ready     (acc_ready_i),
    .ovf_clear (ovf_clear_i),
    .data      (acc_o),
    .valid     (acc_valid_o),
    .overflow  (overflow_o)
  );

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: directed cases plus randomized
// transactions compared against a plain-arithmetic dot-product model.
module tb_mac_accumulator;

`ifdef MAC_ACC_SATURATE_EN
  localparam int ACC_W = 20;
`else
  localparam int ACC_W = 24;
`endif
  localparam int K_MAX = 256;

  logic                    clock_i = 1'b0;
  logic                    reset_i;
  logic                    start_i;
  logic [8:0]              k_len_i;
  logic signed [15:0]      prod_i;
  logic                    prod_valid_i;
  logic                    busy_o;
  logic signed [ACC_W-1:0] acc_o;
  logic                    acc_valid_o;
  logic                    acc_ready_i;
  logic                    overflow_o;
  logic                    ovf_clear_i;

  int     errors = 0;
  int     checks = 0;
  longint prods[$];

  always #5 clock_i = ~clock_i;

  mac_accumulator #(
    .K_MAX (K_MAX),
    .ACC_W (ACC_W)
  ) dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .k_len_i      (k_len_i),
    .prod_i       (prod_i),
    .prod_valid_i (prod_valid_i),
    .busy_o       (busy_o),
    .acc_o        (acc_o),
    .acc_valid_o  (acc_valid_o),
    .acc_ready_i  (acc_ready_i),
    .overflow_o   (overflow_o),
    .ovf_clear_i  (ovf_clear_i)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Dot product of the product list, reduced to the signed ACC_W range.
  function automatic longint ref_result(input longint p[$]);
    longint hi = (longint'(1) <<< (ACC_W - 1)) - 1;
    longint lo = -(longint'(1) <<< (ACC_W - 1));
    longint m  = longint'(1) <<< ACC_W;
    longint s  = 0;
    foreach (p[i]) begin
      s = s + p[i];
`ifdef MAC_ACC_SATURATE_EN
      if (s > hi) s = hi;
      if (s < lo) s = lo;
`endif
    end
    s = s % m;
    if (s > hi) s = s - m;
    if (s < lo) s = s + m;
    return s;
  endfunction

  // Streams the queued products as one accumulation; ends half a cycle after the
  // clock edge that consumed the last beat.
  task automatic accumulate(input int gap_min, input int gap_max, input bit poke_start,
                            input bit out_empty, output longint exp);
    int k;
    k   = prods.size();
    exp = ref_result(prods);
    @(negedge clock_i);
    start_i = 1'b1;
    k_len_i = 9'(k);
    @(negedge clock_i);
    start_i = 1'b0;
    check("busy_after_start", longint'(busy_o), 1);
    for (int i = 0; i < k; i++) begin
      int g;
      g = $urandom_range(gap_max, gap_min);
      repeat (g) @(negedge clock_i);
      if (out_empty && i == k - 1) check("valid_before_last", longint'(acc_valid_o), 0);
      prod_valid_i = 1'b1;
      prod_i       = 16'(prods[i]);
      if (poke_start && i == 0) begin
        start_i = 1'b1;
        k_len_i = 9'd1;
      end
      @(negedge clock_i);
      prod_valid_i = 1'b0;
      start_i      = 1'b0;
      if (i < k - 1) check("busy_mid", longint'(busy_o), 1);
    end
    check("busy_done", longint'(busy_o), 0);
  endtask

  initial begin
    longint exp;
    longint held;
    logic signed [15:0] r;

    reset_i = 1'b1; start_i = 1'b0; k_len_i = '0; prod_i = '0;
    prod_valid_i = 1'b0; acc_ready_i = 1'b1; ovf_clear_i = 1'b0;
    repeat (2) @(negedge clock_i);
    check("rst_busy", longint'(busy_o), 0);
    check("rst_valid", longint'(acc_valid_o), 0);
    check("rst_acc", longint'(acc_o), 0);
    check("rst_ovf", longint'(overflow_o), 0);
    reset_i = 1'b0;

    // Back-to-back beats, result visible one cycle after the last beat, for one cycle.
    prods = '{10, -3, 7, 100};
    accumulate(0, 0, 1'b0, 1'b1, exp);
    check("t1_valid", longint'(acc_valid_o), 1);
    check("t1_acc", longint'(acc_o), exp);
    @(negedge clock_i);
    check("t1_valid_drop", longint'(acc_valid_o), 0);

    // Two idle cycles before every beat.
    prods = '{5, 5, 5};
    accumulate(2, 2, 1'b0, 1'b1, exp);
    check("t2_valid", longint'(acc_valid_o), 1);
    check("t2_acc", longint'(acc_o), exp);
    @(negedge clock_i);

    // Collision with the consumer stalled.
    acc_ready_i = 1'b0;
    prods = '{2, 3};
    accumulate(0, 0, 1'b0, 1'b1, held);
    check("t3_first_acc", longint'(acc_o), held);
    prods = '{1, 1};
    accumulate(0, 1, 1'b0, 1'b0, exp);
    check("t3_held_acc", longint'(acc_o), held);
    check("t3_valid", longint'(acc_valid_o), 1);
    check("t3_ovf", longint'(overflow_o), 1);
    ovf_clear_i = 1'b1;
    @(negedge clock_i);
    ovf_clear_i = 1'b0;
    check("t3_ovf_clr", longint'(overflow_o), 0);

    // A collision in the same cycle as a clear leaves the flag set.
    start_i = 1'b1; k_len_i = 9'd1;
    @(negedge clock_i);
    start_i = 1'b0; prod_valid_i = 1'b1; prod_i = 16'sd9; ovf_clear_i = 1'b1;
    @(negedge clock_i);
    prod_valid_i = 1'b0; ovf_clear_i = 1'b0;
    check("t3_set_prio", longint'(overflow_o), 1);
    check("t3_held_acc2", longint'(acc_o), held);
    ovf_clear_i = 1'b1;
    @(negedge clock_i);
    ovf_clear_i = 1'b0;

    // Completion in the cycle the old result drains: new result loads, no overflow.
    start_i = 1'b1; k_len_i = 9'd1;
    @(negedge clock_i);
    start_i = 1'b0; prod_valid_i = 1'b1; prod_i = -16'sd6; acc_ready_i = 1'b1;
    @(negedge clock_i);
    prod_valid_i = 1'b0; acc_ready_i = 1'b0;
    check("t3_swap_valid", longint'(acc_valid_o), 1);
    check("t3_swap_acc", longint'(acc_o), -6);
    check("t3_swap_ovf", longint'(overflow_o), 0);
    acc_ready_i = 1'b1;
    @(negedge clock_i);
    check("t3_swap_drop", longint'(acc_valid_o), 0);

    // Full-length accumulations at both product extremes.
    prods.delete();
    for (int i = 0; i < K_MAX; i++) prods.push_back(32767);
    accumulate(0, 0, 1'b0, 1'b1, exp);
    check("t4_max_acc", longint'(acc_o), exp);
    prods.delete();
    for (int i = 0; i < K_MAX; i++) prods.push_back(-32768);
    accumulate(0, 0, 1'b0, 1'b1, exp);
    check("t4_min_acc", longint'(acc_o), exp);
    @(negedge clock_i);

    // Reset mid-accumulation aborts it; next result starts clean.
    start_i = 1'b1; k_len_i = 9'd4;
    @(negedge clock_i);
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prod_valid_i = 1'b1; prod_i = 16'sd1000;
      @(negedge clock_i);
    end
    prod_valid_i = 1'b0; reset_i = 1'b1;
    @(negedge clock_i);
    check("t5_rst_busy", longint'(busy_o), 0);
    check("t5_rst_valid", longint'(acc_valid_o), 0);
    reset_i = 1'b0;
    prods = '{-7};
    accumulate(0, 0, 1'b0, 1'b1, exp);
    check("t5_acc", longint'(acc_o), exp);
    @(negedge clock_i);

    // Out-of-range lengths are ignored, and so are the beats that follow.
    for (int t = 0; t < 2; t++) begin
      start_i = 1'b1; k_len_i = (t == 0) ? 9'd0 : 9'd257;
      @(negedge clock_i);
      start_i = 1'b0;
      check("t6_busy", longint'(busy_o), 0);
      for (int i = 0; i < 3; i++) begin
        prod_valid_i = 1'b1; prod_i = 16'sd3;
        @(negedge clock_i);
      end
      prod_valid_i = 1'b0;
      @(negedge clock_i);
      check("t6_no_result", longint'(acc_valid_o), 0);
    end

    // Randomized transactions, some with a stray start during or at completion.
    for (int t = 0; t < 12; t++) begin
      int k;
      k = $urandom_range(12, 1);
      prods.delete();
      for (int i = 0; i < k; i++) begin
        r = 16'($urandom);
        prods.push_back(longint'(r));
      end
      accumulate(0, 2, 1'($urandom_range(1, 0)), 1'b1, exp);
      check("rand_valid", longint'(acc_valid_o), 1);
      check("rand_acc", longint'(acc_o), exp);
      @(negedge clock_i);
      check("rand_drop", longint'(acc_valid_o), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
